// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP transmitter: counter-based frame timing with a four-way RGB565 test-pattern engine.
// Optional per-frame byte checksum output frame_sum is enabled by defining DVP_FRAME_CHECKSUM_EN.
module dvp_pattern_tx #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_TOTAL  = 1568,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BP     = 17,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 510
) (
   input  logic        PCLK,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] solid_rgb,
   output logic        VSYNC,
   output logic        HREF,
   output logic [7:0]  DVP_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
`ifdef DVP_FRAME_CHECKSUM_EN
   ,
   output logic [15:0] frame_sum
`endif
);

   localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int unsigned BAR_W   = H_ACTIVE / 8;
   localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int unsigned V_ACT_S = V_SYNC + V_BP;
   localparam int unsigned V_ACT_E = V_SYNC + V_BP + V_ACTIVE;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      BP     = 3'd2,
      ACTIVE = 3'd3,
      FP     = 3'd4
   } state_t;

   state_t          r_state;
   logic [HW-1:0]   r_h;
   logic [VW-1:0]   r_v;
   logic [1:0]      r_sel;
   logic [15:0]     r_solid;
   logic [7:0]      r_cnt8;
   logic [5:0]      r_x;
   logic [4:0]      r_y;
   logic [BW-1:0]   r_bar_px;
   logic [2:0]      r_bar_idx;

   logic            w_start;
   logic            w_run;
   logic [HW-1:0]   w_h_nxt;
   logic [VW-1:0]   w_v_nxt;
   state_t          w_state_nxt;
   logic            w_href;
   logic            w_vsync;
   logic            w_done;
   logic [1:0]      w_sel;
   logic [15:0]     w_solid;
   logic [7:0]      w_cnt_cur;
   logic [5:0]      w_x_cur;
   logic [4:0]      w_y_cur;
   logic [BW-1:0]   w_bar_px_cur;
   logic [2:0]      w_bar_idx_cur;
   logic [15:0]     w_pix;
   logic [7:0]      w_byte;
   logic            w_px_adv;
   logic            w_line_end;

   // Next (h,v) position; frame_done marks the current cycle as the last of the frame.
   always_comb begin
      w_start = 1'b0;
      w_run   = 1'b0;
      w_h_nxt = '0;
      w_v_nxt = '0;
      if (r_state == IDLE || frame_done) begin
         w_start = en;
         w_run   = en;
      end else begin
         w_run = 1'b1;
         if (r_h == HW'(H_TOTAL - 1)) begin
            w_h_nxt = '0;
            w_v_nxt = r_v + 1'b1;
         end else begin
            w_h_nxt = r_h + 1'b1;
            w_v_nxt = r_v;
         end
      end
   end

   // Region decode and timing outputs for the position being loaded.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_run) begin
         if (w_v_nxt < VW'(V_SYNC))
            w_state_nxt = SYNC;
         else if (w_v_nxt < VW'(V_ACT_S))
            w_state_nxt = BP;
         else if (w_v_nxt < VW'(V_ACT_E))
            w_state_nxt = ACTIVE;
         else
            w_state_nxt = FP;
      end
      w_vsync    = (w_state_nxt == SYNC);
      w_href     = (w_state_nxt == ACTIVE) && (w_h_nxt < HW'(2 * H_ACTIVE));
      w_done     = w_run && (w_v_nxt == VW'(V_TOTAL - 1)) && (w_h_nxt == HW'(H_TOTAL - 1));
      w_px_adv   = w_href && w_h_nxt[0];
      w_line_end = w_href && (w_h_nxt == HW'(2 * H_ACTIVE - 1));
   end

   // Pattern engine; trackers are treated as cleared on the frame-start edge.
   always_comb begin
      w_sel         = w_start ? pattern_sel : r_sel;
      w_solid       = w_start ? solid_rgb   : r_solid;
      w_cnt_cur     = w_start ? 8'h00       : r_cnt8;
      w_x_cur       = w_start ? 6'd0        : r_x;
      w_y_cur       = w_start ? 5'd0        : r_y;
      w_bar_px_cur  = w_start ? '0          : r_bar_px;
      w_bar_idx_cur = w_start ? 3'd0        : r_bar_idx;
      w_pix         = 16'h0000;
      case (w_sel)
         2'd1: begin
            case (w_bar_idx_cur)
               3'd0:    w_pix = 16'hFFFF;
               3'd1:    w_pix = 16'hFFE0;
               3'd2:    w_pix = 16'h07FF;
               3'd3:    w_pix = 16'h07E0;
               3'd4:    w_pix = 16'hF81F;
               3'd5:    w_pix = 16'hF800;
               3'd6:    w_pix = 16'h001F;
               default: w_pix = 16'h0000;
            endcase
         end
         2'd2:    w_pix = w_solid;
         2'd3:    w_pix = {w_y_cur, w_x_cur, w_x_cur[4:0]};
         default: w_pix = 16'h0000;
      endcase
      if (w_sel == 2'd0)
         w_byte = w_cnt_cur;
      else
         w_byte = w_h_nxt[0] ? w_pix[7:0] : w_pix[15:8];
   end

   always_ff @(negedge PCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_h        <= '0;
         r_v        <= '0;
         r_sel      <= 2'd0;
         r_solid    <= 16'h0000;
         r_cnt8     <= 8'h00;
         r_x        <= 6'd0;
         r_y        <= 5'd0;
         r_bar_px   <= '0;
         r_bar_idx  <= 3'd0;
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         DVP_data   <= 8'h00;
         frame_done <= 1'b0;
         frame_cnt  <= 16'h0000;
      end else begin
         r_state    <= w_state_nxt;
         r_h        <= w_h_nxt;
         r_v        <= w_v_nxt;
         VSYNC      <= w_vsync;
         HREF       <= w_href;
         DVP_data   <= w_href ? w_byte : 8'h00;
         frame_done <= w_done;
         if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
         if (w_start) begin
            r_sel   <= pattern_sel;
            r_solid <= solid_rgb;
         end
         r_cnt8 <= w_href ? (w_cnt_cur + 8'd1) : w_cnt_cur;
         // Pixel trackers advance after the low byte; they rewind at the last byte of a line.
         if (w_line_end) begin
            r_x       <= 6'd0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
            r_y       <= w_y_cur + 5'd1;
         end else if (w_px_adv) begin
            r_x <= w_x_cur + 6'd1;
            r_y <= w_y_cur;
            if (w_bar_px_cur == BW'(BAR_W - 1)) begin
               r_bar_px  <= '0;
               r_bar_idx <= w_bar_idx_cur + 3'd1;
            end else begin
               r_bar_px  <= w_bar_px_cur + 1'b1;
               r_bar_idx <= w_bar_idx_cur;
            end
         end else begin
            r_x       <= w_x_cur;
            r_y       <= w_y_cur;
            r_bar_px  <= w_bar_px_cur;
            r_bar_idx <= w_bar_idx_cur;
         end
      end
   end

`ifdef DVP_FRAME_CHECKSUM_EN
   logic [15:0] r_acc;

   // Running sum of transmitted bytes, published when frame_cnt advances.
   always_ff @(negedge PCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= 16'h0000;
         frame_sum <= 16'h0000;
      end else begin
         r_acc <= (w_start ? 16'h0000 : r_acc) + (w_href ? {8'h00, w_byte} : 16'h0000);
         if (frame_done)
            frame_sum <= r_acc;
      end
   end
`endif

endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- Synthesizable DVP camera-side transmitter, OV7670-style: generates PCLK-synchronous VSYNC, HREF and 8-bit DVP_data carrying RGB565 test frames.
- Drives the DVP receiver/FIFO path on hardware without a sensor attached, and serves as the stimulus source for receiver regressions.
- Frame timing is counter-based; content comes from a selectable pattern engine.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes/pixel); multiple of 8, >=8.
- H_TOTAL, 1568, PCLK cycles per line; must be >= 2*H_ACTIVE+1.
- V_SYNC, 3, lines with VSYNC high at frame start.
- V_BP, 17, blank lines between VSYNC fall and first active line.
- V_ACTIVE, 480, active lines per frame.
- V_TOTAL, 510, lines per frame; must be >= V_SYNC+V_BP+V_ACTIVE+1.

Ports:
- PCLK  in  1  pixel clock; all sequential logic on falling edge, so the receiver samples mid-byte on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  frame enable.
- pattern_sel  in  2  0=byte counter, 1=colour bars, 2=solid, 3=gradient.
- solid_rgb  in  16  RGB565 value for pattern 2.
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  line valid, active high.
- DVP_data  out  8  pixel byte.
- frame_done  out  1  one-cycle pulse on last cycle of a frame.
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock PCLK.
- Reset: VSYNC=0, HREF=0, DVP_data=0, frame_done=0, frame_cnt=0; counters h=0, v=0; state IDLE. Takes effect immediately, including mid-line or mid-frame.
- States: IDLE, SYNC (v<V_SYNC), BP, ACTIVE (V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE), FP (remaining lines).
  - SYNC, BP, ACTIVE and FP are decoded from v.
  - h counts 0..H_TOTAL-1; v increments when h wraps.
- IDLE: outputs low; en sampled each falling edge. The edge that samples en=1 loads h=0, v=0 and drives VSYNC=1 at that same edge.
- Outputs are registered and reflect the (h,v) value loaded at the same edge (next-state decode).
- VSYNC=1 for all cycles of lines 0..V_SYNC-1.
- HREF=1 for h in 0..2*H_ACTIVE-1 of ACTIVE lines, else 0.
- DVP_data=0 whenever HREF=0.
- Byte order: byte 2k = pixel[15:8], byte 2k+1 = pixel[7:0]. x = pixel index in line; y = active line index.
- pattern_sel and solid_rgb are latched at frame start. Changes mid-frame have no effect until the next frame.
- Pattern 0: DVP_data = running 8-bit counter. Cleared at frame start, +1 per HREF byte, continues across lines, wraps 255->0.
- Pattern 1: 8 vertical bars, each H_ACTIVE/8 pixels wide: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index tracked by counter, no divider.
- Pattern 2: every pixel = latched solid_rgb.
- Pattern 3: pixel = {y[4:0], x[5:0], x[4:0]}.
- End of frame (v=V_TOTAL-1, h=H_TOTAL-1):
  - frame_done=1 for that cycle; frame_cnt+1 registered on the following edge.
  - If en=1, next edge starts a new frame at h=0, v=0 with no gap; otherwise go to IDLE.
- en deasserted mid-frame: frame runs to completion, then IDLE. No truncated frames.

Optional Feature:
- Macro DVP_FRAME_CHECKSUM_EN.
- When defined, adds output frame_sum (16 bits): the mod-2^16 sum of all DVP_data bytes with HREF=1 in the frame. Accumulator clears at frame start; frame_sum updates on the same edge as frame_cnt; reset value 0.
- When undefined, the port and accumulator are absent.

Test Plan:
- Test params: H_ACTIVE=8, H_TOTAL=20, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_TOTAL=5.
- Reset with en=1 and pattern 0, pulse rst_n low mid-HREF -> VSYNC/HREF/DVP_data/frame_cnt=0 immediately; stays IDLE until rst_n high, then VSYNC rises on first falling edge.
- Pattern 0, en held high -> VSYNC high for 20 cycles; HREF high for 16 cycles on lines 2 and 3; data 0x00..0x0F, then 0x10..0x1F; frame_done at cycle 100; second frame restarts at 0x00; frame_cnt=1 then 2.
- Pattern 1 -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00, identical on both active lines.
- Pattern 2, solid_rgb=0x1234, changed to 0xABCD mid-frame -> current frame 12 34 repeated; next frame AB CD.
- en dropped during line 2 -> frame completes, frame_cnt +1 exactly once, outputs low, no VSYNC until en reasserted.
- DVP_FRAME_CHECKSUM_EN, pattern 0 -> frame_sum = sum(0..31) = 0x01F0 after each frame.
